// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The tenure limit is enabled with RR_ARBITER_TENURE_LIMIT_EN.
package rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int DEF_N          = 4;
    localparam int DEF_MAX_TENURE = 16;
    localparam int MAX_N          = 8;

    // Lowest set bit of a vector already rotated so bit 0 is the pointer slot.
    // Returns {found, offset}.
    function automatic logic [3:0] first_one(input logic [MAX_N-1:0] vec);
        logic [3:0] r;
        r = 4'd0;
        for (int k = MAX_N-1; k >= 0; k--) begin
            if (vec[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority winner search: rotate req by ptr, priority-encode, unrotate.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_win,
    output logic           o_found
);

    logic [N-1:0]     w_rot_n;
    logic [MAX_N-1:0] w_rot;
    logic [3:0]       w_enc;
    logic [IDW:0]     w_sum;

    // Doubling the vector makes the right shift a rotate.
    assign w_rot_n = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_rot          = '0;
        w_rot[N-1:0]   = w_rot_n;
    end

    assign w_enc   = first_one(w_rot);
    assign o_found = w_enc[3];
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_enc[IDW-1:0]};
    assign o_win   = (w_sum >= (IDW+1)'(N)) ? (w_sum[IDW-1:0] - IDW'(N)) : w_sum[IDW-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant and a GAP turnaround cycle.
// Optional forced release after MAX_TENURE cycles: define RR_ARBITER_TENURE_LIMIT_EN.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int IDW        = $clog2(N),
    parameter int MAX_TENURE = DEF_MAX_TENURE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    state_e         r_state, w_nstate;
    logic [IDW-1:0] r_ptr, r_id, w_win, w_ptr_nxt;
    logic [N-1:0]   r_gnt, w_one;
    logic           r_vld, w_found, w_release, w_force;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_found (w_found)
    );

`ifdef RR_ARBITER_TENURE_LIMIT_EN
    localparam int TW = $clog2(MAX_TENURE + 1);
    logic [TW-1:0] r_ten;

    assign w_force = (r_ten == TW'(MAX_TENURE - 1));

    // Zero throughout IDLE, so it is clear on the first GRANT cycle.
    always_ff @(posedge clk) begin
        if (rst)                   r_ten <= '0;
        else if (r_state == GRANT) r_ten <= r_ten + 1'b1;
        else                       r_ten <= '0;
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_release = (r_state == GRANT) && (!req[r_id] || w_force);
    assign w_ptr_nxt = (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;

    always_comb begin
        w_one        = '0;
        w_one[w_win] = 1'b1;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            IDLE:    if (w_found)   w_nstate = GRANT;
            GRANT:   if (w_release) w_nstate = GAP;
            GAP:                    w_nstate = IDLE;
            default:                w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_id    <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if (r_state == IDLE && w_found) begin
                r_gnt <= w_one;
                r_id  <= w_win;
                r_vld <= 1'b1;
            end else if (w_release) begin
                // Pointer moves past the owner so it has lowest priority next round.
                r_gnt <= '0;
                r_id  <= '0;
                r_vld <= 1'b0;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_vld;
    assign gnt_id    = r_id;

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
N-requester round-robin arbiter with a registered one-hot grant, for sharing a single resource such as a bus or shared datapath port. Generalises the two-requester grant FSM so the team can share one resource among 2..8 clients with fairness. A grant is held while the owner keeps requesting. An optional tenure limit forces release. The block sits between the requesting clients and the mux select of the shared resource.

Parameters:
N, 4, number of requesters (2..8)
IDW, $clog2(N), width of gnt_id
MAX_TENURE, 16, max consecutive grant cycles when TENURE_LIMIT_EN is defined (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active high
req  in  N  request vector, bit i = requester i
gnt  out  N  one-hot grant, registered
gnt_valid  out  1  OR of gnt, registered
gnt_id  out  IDW  index of granted requester; 0 when gnt_valid=0

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - gnt=0, gnt_valid=0, gnt_id=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - Tenure counter=0.
  - rst dominates req in the same cycle, including mid-grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod N.
  - Next cycle: gnt[w]=1, gnt_id=w, gnt_valid=1, state=GRANT.
  - Latency is one cycle from req sampled to gnt visible.
  - If req=0, stay in IDLE with outputs 0.
- GRANT:
  - While req[owner]=1, hold gnt unchanged. Other requests are ignored (no preemption).
  - When req[owner]=0 is sampled, next cycle gnt=0, gnt_valid=0, ptr=(owner+1) mod N, state=GAP.
- GAP:
  - One mandatory idle cycle for resource turnaround.
  - Outputs stay 0. Next state is IDLE, and arbitration resumes there.
  - Minimum spacing between two grants is therefore 2 cycles of gnt_valid=0.
- Fairness: with all requests continuously asserted and each owner dropping req after its tenure, grants rotate 0,1,2,...,N-1,0.
- Same-cycle events:
  - A new requester asserting in the same cycle the owner drops waits for IDLE.
  - The current owner re-asserting in GAP gets lowest priority, because ptr has already moved past it.
- Invariant: gnt is always one-hot or zero, never multi-hot.
- X on req bits that are not scanned has no effect. No X propagation on outputs after reset.

Optional Feature:
- Macro: RR_ARBITER_TENURE_LIMIT_EN
- Defined:
  - A tenure counter increments each cycle in GRANT.
  - When the counter reaches MAX_TENURE-1 while req[owner] is still 1, next cycle gnt drops, ptr=(owner+1) mod N, state=GAP (forced release).
  - The counter clears on entry to GRANT.
  - A forced-out owner still requesting competes again in IDLE at its new, lowest priority.
- Undefined:
  - No counter is instantiated and MAX_TENURE is unused.
  - A grant is held indefinitely while the owner requests.

Decomposition:
- Package rr_arbiter_pkg:
  - State enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2).
  - Function for rotating-priority first-one search.
  - Default constants for N and MAX_TENURE.
- One sub-module rr_pick:
  - Combinational rotate, priority-encode, unrotate.
  - Inputs req and ptr; outputs winner index and found flag.
- The FSM, ptr register and tenure counter live in rr_arbiter.

Test Plan (N=4, MAX_TENURE=4):
- Reset with req=4'b1111 → after reset deassert, gnt=0001 one cycle later, gnt_id=0, gnt_valid=1.
- Hold req=0001 for 10 cycles then drop → gnt=0001 for all 10 cycles; gnt=0 for 2 cycles (release + GAP); ptr=1.
- req=4'b1111, each owner drops its req bit 3 cycles after grant and re-asserts in GAP → grant order 0,1,2,3,0; gnt never multi-hot.
- Owner 2 granted, assert rst mid-grant → next cycle gnt=0, gnt_id=0; following grant with req=1111 goes to requester 0.
- With RR_ARBITER_TENURE_LIMIT_EN, req=0011 held constant → gnt=0001 for exactly 4 cycles, 2 idle cycles, gnt=0010 for 4 cycles, alternating.
- Without the macro, same stimulus → gnt=0001 held for the whole 50-cycle run.
